// File: rtl/score_keeper.sv
// Match-state controller: scores, serve pause, game-over and ball hold for a two-player game.
// Optional macro SCORE_BLINK_EN blinks the winner's digit while in game-over.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       left_point,
  input  logic       right_point,
  input  logic       start_btn,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {StIdle, StServe, StPlay, StGameOver} state_e;

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] PauseFrames = 8'(PAUSE_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;
  logic [3:0] left_q, left_d, right_q, right_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic [3:0] left_digit_q, left_digit_d, right_digit_q, right_digit_d;
  logic       hold_q, hold_d;
  logic       game_over_q, game_over_d;

  // Button is idle-high, so the synchroniser resets high to avoid a spurious press.
  logic btn_sync1_q, btn_sync2_q, btn_prev_q, start_evt_q;

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      btn_sync1_q <= 1'b1;
      btn_sync2_q <= 1'b1;
      btn_prev_q  <= 1'b1;
      start_evt_q <= 1'b0;
    end else begin
      btn_sync1_q <= start_btn;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
      start_evt_q <= btn_prev_q & ~btn_sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    unique case (state_q)
      StIdle: begin
        left_d  = 4'd0;
        right_d = 4'd0;
        if (start_evt_q) begin
          state_d     = StServe;
          pause_cnt_d = 8'd0;
        end
      end
      StServe: begin
        if (frame_tick) begin
          pause_cnt_d = pause_cnt_q + 8'd1;
          if (pause_cnt_d == PauseFrames) state_d = StPlay;
        end
      end
      StPlay: begin
        // Simultaneous pulses cancel out entirely.
        if (left_point ^ right_point) begin
          serve_dir_d = right_point;
          state_d     = StServe;
          pause_cnt_d = 8'd0;
          if (left_point) begin
            left_d = left_q + 4'd1;
            if (left_d == WinScore) begin
              state_d  = StGameOver;
              winner_d = 1'b0;
            end
          end else begin
            right_d = right_q + 4'd1;
            if (right_d == WinScore) begin
              state_d  = StGameOver;
              winner_d = 1'b1;
            end
          end
        end
      end
      StGameOver: begin
        if (start_evt_q) begin
          left_d      = 4'd0;
          right_d     = 4'd0;
          winner_d    = 1'b0;
          serve_dir_d = 1'b0;
          state_d     = StServe;
          pause_cnt_d = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign hold_d      = (state_d != StPlay);
  assign game_over_d = (state_d == StGameOver);

`ifdef SCORE_BLINK_EN
  localparam logic [7:0] BlinkFrames = 8'(BLINK_FRAMES);

  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_off_q, blink_off_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    // Held clear outside game-over so each match end starts with the digit visible.
    if (state_d != StGameOver) begin
      blink_cnt_d = 8'd0;
      blink_off_d = 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q + 8'd1 == BlinkFrames) begin
        blink_cnt_d = 8'd0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= 8'd0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign left_digit_d  = (blink_off_d && !winner_d) ? 4'hF : left_d;
  assign right_digit_d = (blink_off_d && winner_d) ? 4'hF : right_d;
`else
  logic unused_blink;
  assign unused_blink  = (BLINK_FRAMES == 0);
  assign left_digit_d  = left_d;
  assign right_digit_d = right_d;
`endif

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pause_cnt_q   <= 8'd0;
      left_q        <= 4'd0;
      right_q       <= 4'd0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      left_digit_q  <= 4'd0;
      right_digit_q <= 4'd0;
      hold_q        <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pause_cnt_q   <= pause_cnt_d;
      left_q        <= left_d;
      right_q       <= right_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      left_digit_q  <= left_digit_d;
      right_digit_q <= right_digit_d;
      hold_q        <= hold_d;
      game_over_q   <= game_over_d;
    end
  end

  assign left_digit  = left_digit_q;
  assign right_digit = right_digit_q;
  assign ball_hold   = hold_q;
  assign serve_dir   = serve_dir_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed table-driven bench for score_keeper with default parameters.
module tb_score_keeper;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       frame_tick, left_point, right_point, start_btn;
  logic [3:0] left_digit, right_digit;
  logic       ball_hold, serve_dir, game_over, winner;

  int total = 0;
  int bad   = 0;

  score_keeper dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .left_point  (left_point),
    .right_point (right_point),
    .start_btn   (start_btn),
    .left_digit  (left_digit),
    .right_digit (right_digit),
    .ball_hold   (ball_hold),
    .serve_dir   (serve_dir),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    int         pre;
    logic       tick;
    logic       lp;
    logic       rp;
    logic [3:0] el;
    logic [3:0] er;
    logic       eh;
    logic       ed;
    logic       eg;
    logic       ew;
  } vec_t;

  vec_t tbl[0:17];

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic l, input logic r);
    frame_tick  = f;
    left_point  = l;
    right_point = r;
    @(posedge clk_0);
    #1;
    frame_tick  = 1'b0;
    left_point  = 1'b0;
    right_point = 1'b0;
  endtask

  task automatic serve();
    repeat (60) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press();
    start_btn = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    start_btn = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".left"}, left_digit, 4'd0);
    chk({nm, ".right"}, right_digit, 4'd0);
    chk({nm, ".hold"}, ball_hold, 1'b1);
    chk({nm, ".dir"}, serve_dir, 1'b0);
    chk({nm, ".go"}, game_over, 1'b0);
    chk({nm, ".win"}, winner, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    frame_tick = 1'b0;
    left_point = 1'b0;
    right_point = 1'b0;
    start_btn = 1'b1;
    repeat (2) @(posedge clk_0);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Start, then serve release exactly after the 60th tick.
    press();
    repeat (59) cyc(1'b1, 1'b0, 1'b0);
    chk("tick59.hold", ball_hold, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tick60.hold", ball_hold, 1'b0);

    // Rows: pre-ticks, final tick/left/right, then expected l, r, hold, dir, go, win.
    tbl[0]  = '{0,  1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{0,  1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{60, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0,  1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{59, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1,  1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,  1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{59, 1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{0,  1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 3; k <= 8; k++) begin
      tbl[k + 6] = '{60, 1'b0, 1'b1, 1'b0, 4'(k), 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    end
    tbl[15] = '{60, 1'b0, 1'b1, 1'b0, 4'd9, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{0,  1'b0, 1'b0, 1'b1, 4'd9, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{0,  1'b0, 1'b1, 1'b1, 4'd9, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 18; i++) begin
      repeat (tbl[i].pre) cyc(1'b1, 1'b0, 1'b0);
      cyc(tbl[i].tick, tbl[i].lp, tbl[i].rp);
      chk($sformatf("v%0d.left", i), left_digit, tbl[i].el);
      chk($sformatf("v%0d.right", i), right_digit, tbl[i].er);
      chk($sformatf("v%0d.hold", i), ball_hold, tbl[i].eh);
      chk($sformatf("v%0d.dir", i), serve_dir, tbl[i].ed);
      chk($sformatf("v%0d.go", i), game_over, tbl[i].eg);
      chk($sformatf("v%0d.win", i), winner, tbl[i].ew);
    end

    // Winner digit over two blink half-periods; loser digit static.
    for (int k = 1; k <= 30; k++) begin
      logic [3:0] exp_l;
      cyc(1'b1, 1'b0, 1'b0);
`ifdef SCORE_BLINK_EN
      exp_l = (k >= 15 && k < 30) ? 4'hF : 4'd9;
`else
      exp_l = 4'd9;
`endif
      chk($sformatf("blink%0d.left", k), left_digit, exp_l);
    end
    chk("blink.right", right_digit, 4'd2);

    // Restart from game-over: event lands 3 edges after the press, state on the 4th.
    start_btn = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("restart3.go", game_over, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_reset("restart4");
    start_btn = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Right player wins 0-9.
    for (int i = 0; i < 9; i++) begin
      serve();
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("rwin.left", left_digit, 4'd0);
    chk("rwin.right", right_digit, 4'd9);
    chk("rwin.go", game_over, 1'b1);
    chk("rwin.win", winner, 1'b1);
    chk("rwin.dir", serve_dir, 1'b1);
    press();
    chk_reset("rwin.restart");

    // Start press during play is ignored.
    serve();
    press();
    chk("play_start.hold", ball_hold, 1'b0);

    // Reach 3-2 mid-serve, then assert reset asynchronously.
    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) begin
      serve();
      cyc(1'b0, 1'b1, 1'b0);
    end
    repeat (2) begin
      serve();
      cyc(1'b0, 1'b0, 1'b1);
    end
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst.left", left_digit, 4'd3);
    chk("pre_rst.right", right_digit, 4'd2);
    chk("pre_rst.hold", ball_hold, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge clk_0);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk_reset("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match-state controller upstream of the score digit renderer. It counts points for the left and right players from single-cycle point pulses issued by the ball logic, and drives one 4-bit digit per player into the score display stage. It sequences the match through idle, serve pause, play and game-over, and holds the ball between rallies.

## Interface
- `WIN_SCORE`, 9: score that ends the match; legal range 1..9.
- `PAUSE_FRAMES`, 60: number of frame ticks the ball is held before each serve; legal range 1..255.
- `BLINK_FRAMES`, 15: frame ticks per blink half-period; used only with `SCORE_BLINK_EN`.

- `clk_0`  in  1  25.175 MHz pixel clock.
- `rst`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `left_point`  in  1  one-cycle pulse: the left player scored.
- `right_point`  in  1  one-cycle pulse: the right player scored.
- `start_btn`  in  1  raw active-low push button, asynchronous to `clk_0`.
- `left_digit`  out  4  left score digit to the display stage.
- `right_digit`  out  4  right score digit to the display stage.
- `ball_hold`  out  1  1 = the ball logic must park the ball at centre.
- `serve_dir`  out  1  direction of the next serve: 0 = toward left, 1 = toward right.
- `game_over`  out  1  1 while in GAME_OVER.
- `winner`  out  1  0 = left won, 1 = right won; valid only while `game_over` = 1.

## Operation
- **Start input:** `start_btn` passes through a two-flop synchroniser. A falling edge on the synchronised signal produces `start_evt`, one cycle wide.
- **States:** IDLE, SERVE, PLAY, GAME_OVER.
- **IDLE:** scores are 0. On `start_evt`, go to SERVE.
- **SERVE:** the pause counter clears on entry and increments on each `frame_tick`. When the count reaches `PAUSE_FRAMES`, go to PLAY. Point pulses and `start_evt` are ignored.
- **PLAY, point scored:**
  - Exactly one of `left_point`/`right_point` high increments that player's score by 1.
  - If the new score equals `WIN_SCORE`, go to GAME_OVER and set `winner` to the scorer.
  - Otherwise go to SERVE.
  - `serve_dir` is set toward the scorer: 0 if left scored, 1 if right scored. The player who conceded serves.
- **PLAY, simultaneous points:** both pulses high in the same cycle are discarded. There is no score change and no state change.
- **GAME_OVER:** scores are frozen. On `start_evt`, clear both scores and `winner`, set `serve_dir` = 0, and go to SERVE.
- **Score width:** scores are 4-bit unsigned and never exceed `WIN_SCORE`. No wrap-around can occur.
- **Outputs:**
  - `left_digit` and `right_digit` equal the scores, except during blanking (see Configuration).
  - Digit code 4'hF renders blank in the display stage.
  - `ball_hold` = 1 in IDLE, SERVE and GAME_OVER; 0 only in PLAY.

## Timing
- All outputs are registered.
- **Reset values:**
  - `left_digit` = 0, `right_digit` = 0.
  - `ball_hold` = 1, `serve_dir` = 0, `game_over` = 0, `winner` = 0.
  - State = IDLE; pause counter and blink state = 0.
- **Asserting `rst`:** reset takes effect immediately from any state, including mid-pause and mid-blink.
- **Point latency:** a point pulse at edge N updates the digit, state and `ball_hold` at edge N+1.
- **Start latency:** a button press reaches `start_evt` 3 edges after the raw edge: 2 synchroniser stages plus 1 edge-detect stage. State changes on the following edge.
- **Serve release:** `ball_hold` falls on the edge after the `PAUSE_FRAMES`-th `frame_tick` counted in SERVE. A `frame_tick` in the same cycle as entry into SERVE is not counted.
- **Overlapping events:** a point pulse coincident with the SERVE→PLAY transition edge is ignored, because the point is sampled while the state is still SERVE.
- **`start_evt` in PLAY:** ignored; there is no restart mid-rally.

## Configuration
- **Macro:** `SCORE_BLINK_EN`.
- **Defined:**
  - In GAME_OVER, the winner's digit alternates between its score and 4'hF every `BLINK_FRAMES` frame ticks.
  - The digit is visible for the first half-period after entry into GAME_OVER.
  - The loser's digit stays static.
  - Leaving GAME_OVER restores the static digit on the same edge.
- **Undefined:**
  - Digits are always the raw scores.
  - No blink counter is instantiated, and `BLINK_FRAMES` is unused.

## Test plan
- **Reset:** drop `rst` low mid-SERVE with scores 3–2 → all outputs return to reset values immediately, and digits read 0–0.
- **Start and serve:** press `start_btn`, then drive 60 frame ticks with defaults → `ball_hold` deasserts exactly one edge after the 60th tick; the 59th tick leaves it at 1.
- **Point:** `right_point` pulse in PLAY → `right_digit` goes 0→1 on the next edge, `serve_dir` = 1, state SERVE, `ball_hold` = 1.
- **Simultaneous pulses:** `left_point` and `right_point` high together in PLAY → digits unchanged and state stays PLAY. A point pulse during SERVE → no change.
- **Win:** drive the left score to 9 → `game_over` = 1, `winner` = 0, digits frozen at 9–x. Further point pulses are ignored. `start_evt` → digits 0–0 and state SERVE.
- **Blink (`SCORE_BLINK_EN` defined):** left wins 9–4 → `left_digit` shows 9 for 15 ticks, then 4'hF for 15 ticks, repeating; `right_digit` holds 4. With the macro undefined → `left_digit` holds 9.
